// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port integer register file with a busy-bit scoreboard.
//             NREAD combinational read ports, NWRITE synchronous write ports,
//             optional same-cycle write-to-read forwarding, and one pending
//             bit per register for decode-stage hazard detection.
//             Register 0 is hardwired to zero and is never busy.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NREAD*$clog2(NREGS)-1:0]       ra,
    output logic [NREAD*XLEN-1:0]                rd,
    output logic [NREAD-1:0]                     rbusy,
    input  logic [NWRITE-1:0]                    wen,
    input  logic [NWRITE*$clog2(NREGS)-1:0]      wa,
    input  logic [NWRITE*XLEN-1:0]               wd,
    input  logic [NWRITE-1:0]                    wclr,
    input  logic                                 alloc_en,
    input  logic [$clog2(NREGS)-1:0]             alloc_addr,
    input  logic                                 flush
);

    localparam int c_AW = $clog2(NREGS);

    // ------------------------------------------------------------------
    // Unpack the flat write-port buses into per-port views
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_wa [NWRITE];
    logic [XLEN-1:0] w_wd [NWRITE];

    generate
        for (genvar gj = 0; gj < NWRITE; gj++) begin : g_wport
            assign w_wa[gj] = wa[gj*c_AW +: c_AW];
            assign w_wd[gj] = wd[gj*XLEN +: XLEN];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register storage. Entry 0 is reset to zero and never written, so it
    // reads as zero forever. Ports are visited in ascending order, so the
    // last non-blocking assignment (highest port index) wins a collision.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREGS];

    // Storage update: async clear, then apply every enabled write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && (w_wa[j] != '0)) begin
                    r_regs[w_wa[j]] <= w_wd[j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy-bit scoreboard
    // ------------------------------------------------------------------
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy state: flush dominates; otherwise clears are applied first
    // and the allocation last, so a new producer owns the register even when
    // an older producer retires it in the same cycle.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && wclr[j] && (w_wa[j] != '0)) begin
                    w_busy_nxt[w_wa[j]] = 1'b0;
                end
            end
            if (alloc_en && (alloc_addr != '0)) begin
                w_busy_nxt[alloc_addr] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy register: async clear, otherwise take the computed next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rport
            logic [c_AW-1:0] w_ra;
            logic [XLEN-1:0] w_rdata;
            logic            w_rbusy;

            assign w_ra = ra[gi*c_AW +: c_AW];

            // Read mux with optional forwarding of this cycle's write data;
            // the highest matching port wins, and any matching retiring
            // write hides the busy bit because its value is arriving now.
            always_comb begin
                w_rdata = (w_ra == '0) ? '0 : r_regs[w_ra];
                w_rbusy = r_busy[w_ra];
                if ((BYPASS != 0) && !reset && (w_ra != '0)) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (wen[j] && (w_wa[j] == w_ra)) begin
                            w_rdata = w_wd[j];
                            if (wclr[j]) begin
                                w_rbusy = 1'b0;
                            end
                        end
                    end
                end
            end

            assign rd[gi*XLEN +: XLEN] = w_rdata;
            assign rbusy[gi]           = w_rbusy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Two instances (no bypass
//             and bypass, both with two write ports) share one stimulus
//             stream and are compared against a behavioural model every
//             cycle, plus hand-computed directed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NREAD*AW-1:0]     ra = '0;
    logic [NWRITE-1:0]       wen = '0;
    logic [NWRITE*AW-1:0]    wa = '0;
    logic [NWRITE*XLEN-1:0]  wd = '0;
    logic [NWRITE-1:0]       wclr = '0;
    logic                    alloc_en = 1'b0;
    logic [AW-1:0]           alloc_addr = '0;
    logic                    flush = 1'b0;

    logic [NREAD*XLEN-1:0]   rd_nb, rd_bp;
    logic [NREAD-1:0]        rbusy_nb, rbusy_bp;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
        .wen(wen), .wa(wa), .wd(wd), .wclr(wclr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1)) dut_bp (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_bp), .rbusy(rbusy_bp),
        .wen(wen), .wa(wa), .wd(wd), .wclr(wclr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
    );

    // ------------------------------------------------------------------
    // Behavioural model: architectural register array and busy set
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];

    function automatic logic [AW-1:0] wa_of(int j);
        return wa[j*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] wd_of(int j);
        return wd[j*XLEN +: XLEN];
    endfunction

    // Model state update: writes in port order, then busy rules
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                m_reg[k]  <= '0;
                m_busy[k] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && wa_of(j) != 0) m_reg[wa_of(j)] <= wd_of(j);
            end
            if (flush) begin
                for (int k = 0; k < NREGS; k++) m_busy[k] <= 1'b0;
            end else begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wen[j] && wclr[j] && wa_of(j) != 0) m_busy[wa_of(j)] <= 1'b0;
                end
                if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] <= 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(int i, bit byp);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        a = ra[i*AW +: AW];
        if (reset) return '0;
        v = (a == 0) ? '0 : m_reg[a];
        if (byp && a != 0) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && wa_of(j) == a) v = wd_of(j);
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(int i, bit byp);
        logic [AW-1:0] a;
        logic          b;
        a = ra[i*AW +: AW];
        if (reset || a == 0) return 1'b0;
        b = m_busy[a];
        if (byp) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && wclr[j] && wa_of(j) == a) b = 1'b0;
            end
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NREAD; i++) begin
                check($sformatf("rd_nb[%0d]", i), rd_nb[i*XLEN +: XLEN], exp_rd(i, 1'b0));
                check($sformatf("rd_bp[%0d]", i), rd_bp[i*XLEN +: XLEN], exp_rd(i, 1'b1));
                check($sformatf("rbusy_nb[%0d]", i), XLEN'(rbusy_nb[i]), XLEN'(exp_busy(i, 1'b0)));
                check($sformatf("rbusy_bp[%0d]", i), XLEN'(rbusy_bp[i]), XLEN'(exp_busy(i, 1'b1)));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wen = '0; wclr = '0; alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    task automatic set_w(input int j, input int a, input logic [XLEN-1:0] d, input bit clr);
        wen[j] = 1'b1;
        wclr[j] = clr;
        wa[j*AW +: AW] = AW'(a);
        wd[j*XLEN +: XLEN] = d;
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NREGS-1));
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        #1;
        chk_en = 1'b1;
        adv(); adv();
        reset = 1'b0;

        // All registers read zero and idle on every port after reset
        for (int r = 0; r < NREGS; r++) begin
            set_ra(r, NREGS-1-r);
            samp();
            check("reset_rd0", rd_nb[XLEN-1:0], '0);
            check("reset_rd1", rd_bp[2*XLEN-1:XLEN], '0);
            check("reset_busy", XLEN'({rbusy_nb, rbusy_bp}), '0);
            adv();
        end

        // Write to x0 is dropped
        set_w(0, 0, 64'hDEAD, 1'b0); set_ra(0, 0);
        adv(); idle();
        samp();
        check("x0_nb", rd_nb[XLEN-1:0], '0);
        check("x0_bp", rd_bp[XLEN-1:0], '0);
        adv();

        // x5: old value in the write cycle without bypass, new with bypass
        set_w(0, 5, 64'h1234, 1'b0); set_ra(5, 5);
        samp();
        check("x5_same_nb", rd_nb[XLEN-1:0], 64'h0);
        check("x5_same_bp", rd_bp[XLEN-1:0], 64'h1234);
        adv(); idle();
        samp();
        check("x5_next_nb", rd_nb[XLEN-1:0], 64'h1234);
        adv();

        // Both ports hit x7: highest port wins
        set_w(0, 7, 64'hAAAA, 1'b0); set_w(1, 7, 64'hBBBB, 1'b0); set_ra(7, 7);
        samp();
        check("x7_fwd_bp", rd_bp[2*XLEN-1:XLEN], 64'hBBBB);
        adv(); idle();
        samp();
        check("x7_nb", rd_nb[XLEN-1:0], 64'hBBBB);
        adv();

        // Different addresses: both updated
        set_w(0, 8, 64'h1111, 1'b0); set_w(1, 9, 64'h2222, 1'b0);
        adv(); idle(); set_ra(8, 9);
        samp();
        check("x8_nb", rd_nb[XLEN-1:0], 64'h1111);
        check("x9_nb", rd_nb[2*XLEN-1:XLEN], 64'h2222);
        adv();

        // Allocate x3: busy shows up the next cycle and persists
        alloc_en = 1'b1; alloc_addr = 5'd3; set_ra(3, 3);
        samp();
        check("x3_alloc_same", XLEN'(rbusy_nb[0]), '0);
        adv(); idle(); adv(); adv();
        samp();
        check("x3_busy_nb", XLEN'(rbusy_nb[0]), 64'd1);
        check("x3_busy_bp", XLEN'(rbusy_bp[0]), 64'd1);
        adv();

        // Retiring write to x3
        set_w(0, 3, 64'h33, 1'b1);
        samp();
        check("x3_clr_same_nb", XLEN'(rbusy_nb[0]), 64'd1);
        check("x3_clr_same_bp", XLEN'(rbusy_bp[0]), 64'd0);
        adv(); idle();
        samp();
        check("x3_clr_next_nb", XLEN'(rbusy_nb[0]), 64'd0);
        adv();

        // Same-cycle allocate and retire of x3: stays busy, data updated
        set_w(0, 3, 64'h44, 1'b1); alloc_en = 1'b1; alloc_addr = 5'd3;
        adv(); idle();
        samp();
        check("x3_setwins", XLEN'(rbusy_nb[0]), 64'd1);
        check("x3_data", rd_nb[XLEN-1:0], 64'h44);
        adv();

        // Allocate x1, x2, x9, then flush together with alloc x4
        alloc_en = 1'b1; alloc_addr = 5'd1; adv();
        alloc_addr = 5'd2; adv();
        alloc_addr = 5'd9; adv();
        idle(); set_ra(9, 2);
        samp();
        check("x9_busy", XLEN'(rbusy_nb[0]), 64'd1);
        check("x2_busy", XLEN'(rbusy_nb[1]), 64'd1);
        adv();
        flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd4;
        adv(); idle();
        for (int r = 1; r < 10; r++) begin
            set_ra(r, 4);
            samp();
            check("flush_busy", XLEN'(rbusy_nb[0]), '0);
            check("flush_x4", XLEN'(rbusy_nb[1]), '0);
            adv();
        end
        set_ra(9, 3);
        samp();
        check("flush_keep_x9", rd_nb[XLEN-1:0], 64'h2222);
        check("flush_keep_x3", rd_nb[2*XLEN-1:XLEN], 64'h44);
        adv();

        // Asynchronous reset between edges
        set_w(0, 10, 64'h55, 1'b0); alloc_en = 1'b1; alloc_addr = 5'd10;
        adv(); idle(); set_ra(10, 10);
        samp();
        check("x10_pre", rd_nb[XLEN-1:0], 64'h55);
        check("x10_busy_pre", XLEN'(rbusy_nb[0]), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("x10_async_rd_nb", rd_nb[XLEN-1:0], '0);
        check("x10_async_rd_bp", rd_bp[XLEN-1:0], '0);
        check("x10_async_busy", XLEN'({rbusy_nb, rbusy_bp}), '0);
        adv();
        reset = 1'b0;
        adv();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wen        = NWRITE'($urandom);
            wclr       = NWRITE'($urandom);
            for (int j = 0; j < NWRITE; j++) begin
                wa[j*AW +: AW]     = AW'(rand_addr());
                wd[j*XLEN +: XLEN] = {$urandom, $urandom};
            end
            alloc_en   = ($urandom_range(0, 3) == 0);
            alloc_addr = AW'(rand_addr());
            flush      = ($urandom_range(0, 49) == 0);
            set_ra(rand_addr(), rand_addr());
            reset      = ($urandom_range(0, 399) == 0);
            adv();
        end
        idle();
        reset = 1'b0;
        adv();
        adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
